// File: rtl/sonar_array.sv
`default_nettype none
// ==========================================================================
// sonar_array : round-robin multi-channel ultrasonic trigger/echo ranging
// Revision    : 1.0
// ==========================================================================
module sonar_array #(
    parameter int NUM_CH       = 4,
    parameter int DIST_W       = 14,
    parameter int DIV          = 29,
    parameter int TRIG_CYCLES  = 500,
    parameter int RISE_TIMEOUT = 1_500_000,
    parameter int GAP_CYCLES   = 100_000,
    parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic [NUM_CH-1:0]        echo,
    output logic [NUM_CH-1:0]        trig,
    output logic [NUM_CH*DIST_W-1:0] distance,
    output logic [NUM_CH-1:0]        overflow,
    output logic [NUM_CH-1:0]        no_echo,
    output logic                     valid,
    output logic [CH_W-1:0]          valid_ch,
    output logic                     busy
);

    localparam int TMR_MAX0 = (TRIG_CYCLES > GAP_CYCLES) ? TRIG_CYCLES : GAP_CYCLES;
    localparam int TMR_MAX  = (RISE_TIMEOUT > TMR_MAX0) ? RISE_TIMEOUT : TMR_MAX0;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);
    localparam int PRE_W    = $clog2(DIV);

    localparam logic [TMR_W-1:0]  TRIG_LAST = TMR_W'(TRIG_CYCLES - 1);
    localparam logic [TMR_W-1:0]  RISE_LAST = TMR_W'(RISE_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]  GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(DIV - 1);
    localparam logic [DIST_W-1:0] DIST_MAX  = '1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TRIG      = 3'd1;
    localparam logic [2:0] S_WAIT_RISE = 3'd2;
    localparam logic [2:0] S_MEASURE   = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;

    logic [2:0]               state_q, state_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [TMR_W-1:0]         timer_q, timer_d;
    logic [PRE_W-1:0]         presc_q, presc_d;
    logic [DIST_W-1:0]        count_q, count_d;
    logic [NUM_CH-1:0]        sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NUM_CH-1:0]        trig_q, trig_d;
    logic [NUM_CH*DIST_W-1:0] dist_q, dist_d;
    logic [NUM_CH-1:0]        ovf_q, ovf_d, noe_q, noe_d;
    logic                     valid_q, valid_d;
    logic [CH_W-1:0]          valid_ch_q, valid_ch_d;

    logic                     e_s;
    logic                     rise_to, fall_rec, sat_rec;
    logic [CH_W-1:0]          next_ch, next_idx;

    assign e_s = sync2_q[ch_q];

    // Lowest enabled channel strictly after the current one, wrapping.
    always_comb begin
        next_ch  = ch_q;
        next_idx = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            next_idx = CH_W'((int'(ch_q) + k) % NUM_CH);
            if (ch_mask[next_idx]) begin
                next_ch = next_idx;
            end
        end
    end

    always_comb begin
        rise_to  = (state_q == S_WAIT_RISE) && !e_s && (timer_q == RISE_LAST);
        fall_rec = (state_q == S_MEASURE) && !e_s;
        sat_rec  = (state_q == S_MEASURE) && e_s && (presc_q == PRE_LAST) &&
                   (count_q == DIST_MAX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ch_q       <= CH_W'(NUM_CH - 1);
            timer_q    <= '0;
            presc_q    <= '0;
            count_q    <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            trig_q     <= '0;
            dist_q     <= '0;
            ovf_q      <= '0;
            noe_q      <= '0;
            valid_q    <= 1'b0;
            valid_ch_q <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            timer_q    <= timer_d;
            presc_q    <= presc_d;
            count_q    <= count_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            trig_q     <= trig_d;
            dist_q     <= dist_d;
            ovf_q      <= ovf_d;
            noe_q      <= noe_d;
            valid_q    <= valid_d;
            valid_ch_q <= valid_ch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        timer_d = timer_q;
        presc_d = presc_q;
        count_d = count_q;
        sync1_d = echo;
        sync2_d = sync1_q;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (enable && (|ch_mask)) begin
                    state_d = S_TRIG;
                    ch_d    = next_ch;
                end
            end
            S_TRIG: begin
                if (timer_q == TRIG_LAST) begin
                    state_d = S_WAIT_RISE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WAIT_RISE: begin
                // The rise cycle is itself a high cycle, so the prescaler starts at 1.
                if (e_s) begin
                    state_d = S_MEASURE;
                    presc_d = PRE_W'(1);
                    count_d = '0;
                end else if (rise_to) begin
                    state_d = S_GAP;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_MEASURE: begin
                if (fall_rec || sat_rec) begin
                    state_d = S_GAP;
                    timer_d = '0;
                end else if (presc_q == PRE_LAST) begin
                    presc_d = '0;
                    count_d = count_q + 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            S_GAP: begin
                if ((timer_q >= GAP_LAST) && !e_s) begin
                    timer_d = '0;
                    if (enable && (|ch_mask)) begin
                        state_d = S_TRIG;
                        ch_d    = next_ch;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (timer_q < GAP_LAST) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        trig_d     = (state_d == S_TRIG) ? (NUM_CH'(1) << ch_d) : '0;
        dist_d     = dist_q;
        ovf_d      = ovf_q;
        noe_d      = noe_q;
        valid_d    = rise_to || fall_rec || sat_rec;
        valid_ch_d = valid_d ? ch_q : '0;
        if (valid_d) begin
            dist_d[int'(ch_q)*DIST_W +: DIST_W] = fall_rec ? count_q : DIST_MAX;
            ovf_d[ch_q]                         = sat_rec;
            noe_d[ch_q]                         = rise_to;
        end
    end

    assign trig     = trig_q;
    assign distance = dist_q;
    assign overflow = ovf_q;
    assign no_echo  = noe_q;
    assign valid    = valid_q;
    assign valid_ch = valid_ch_q;
    assign busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire
